// File: rtl/rx_timing_ctrl.sv
// Symbol-timing-recovery sequencer for one received packet: preamble search, settle masking,
// per-symbol bit delivery and done / lock-lost / search-timeout status.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start with a nonzero symbol count
//   SEARCH | waiting for correlator hit, optional sample timeout
//   SETTLE | recovery pipeline settling, symbol strobes ignored
//   TRACK  | one bit per symbol strobe, watchdog on missing strobes
//   DONE   | last bit delivered, single cycle
//   LOST   | watchdog expired, single cycle
module rx_timing_ctrl #(
    parameter int SAMPLE_RATE    = 16,
    parameter int SETTLE_SAMPLES = 9,
    parameter int LEN_W          = 10,
    parameter int SEARCH_TO_W    = 12
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   en,
    input  logic                   start,
    input  logic                   abort,
    input  logic [LEN_W-1:0]       num_symbols,
    input  logic [SEARCH_TO_W-1:0] search_timeout,
    input  logic                   preamble_hit,
    input  logic                   symbol_clk,
    input  logic                   demod_bit,
    output logic                   cr_en,
    output logic                   cr_preamble,
    output logic                   bit_valid,
    output logic                   bit_data,
    output logic [LEN_W-1:0]       sym_count,
    output logic                   busy,
    output logic                   packet_done,
    output logic                   lock_lost,
    output logic                   search_to
);

    localparam int WD_W = $clog2(2 * SAMPLE_RATE) + 1;
    localparam int ST_W = $clog2(SETTLE_SAMPLES + 1);

    localparam logic [WD_W-1:0]        WD_LIMIT    = WD_W'(2 * SAMPLE_RATE);
    localparam logic [WD_W-1:0]        WD_ONE      = WD_W'(1);
    localparam logic [ST_W-1:0]        SETTLE_LAST = ST_W'(SETTLE_SAMPLES - 1);
    localparam logic [ST_W-1:0]        ST_ONE      = ST_W'(1);
    localparam logic [SEARCH_TO_W-1:0] TO_ONE      = SEARCH_TO_W'(1);
    localparam logic [LEN_W-1:0]       LEN_ONE     = LEN_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEARCH = 3'd1,
        S_SETTLE = 3'd2,
        S_TRACK  = 3'd3,
        S_DONE   = 3'd4,
        S_LOST   = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [LEN_W-1:0]       num_lat;
    logic [SEARCH_TO_W-1:0] to_lat;
    logic [SEARCH_TO_W-1:0] search_cnt;
    logic [ST_W-1:0]        settle_cnt;
    logic [WD_W-1:0]        wd_cnt;

    logic [SEARCH_TO_W-1:0] search_inc;
    logic [LEN_W-1:0]       sym_inc;
    logic [WD_W-1:0]        wd_inc;

    logic accept_start;
    logic take_hit;
    logic search_expire;
    logic settle_end;
    logic take_bit;
    logic last_bit;
    logic wd_expire;

    assign search_inc = search_cnt + TO_ONE;
    assign sym_inc    = sym_count + LEN_ONE;
    assign wd_inc     = wd_cnt + WD_ONE;

    // Event decode; every event except start is qualified by en.
    assign accept_start  = (state == S_IDLE) && start && (num_symbols != '0) && !abort;
    assign take_hit      = (state == S_SEARCH) && en && preamble_hit;
    assign search_expire = (state == S_SEARCH) && en && !preamble_hit &&
                           (to_lat != '0) && (search_inc == to_lat);
    assign settle_end    = (state == S_SETTLE) && en && (settle_cnt == SETTLE_LAST);
    assign take_bit      = (state == S_TRACK) && en && symbol_clk;
    assign last_bit      = take_bit && (sym_inc == num_lat);
    assign wd_expire     = (state == S_TRACK) && en && !symbol_clk && (wd_inc == WD_LIMIT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept_start) state_nxt = S_SEARCH;
                end
                S_SEARCH: begin
                    if (take_hit)           state_nxt = S_SETTLE;
                    else if (search_expire) state_nxt = S_IDLE;
                end
                S_SETTLE: begin
                    if (settle_end) state_nxt = S_TRACK;
                end
                S_TRACK: begin
                    if (last_bit)       state_nxt = S_DONE;
                    else if (wd_expire) state_nxt = S_LOST;
                end
                S_DONE:  state_nxt = S_IDLE;
                S_LOST:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy        = (state != S_IDLE);
        packet_done = (state == S_DONE);
        lock_lost   = (state == S_LOST);
        cr_en       = en && ((state == S_SEARCH) || (state == S_SETTLE) || (state == S_TRACK));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            num_lat     <= '0;
            to_lat      <= '0;
            search_cnt  <= '0;
            settle_cnt  <= '0;
            wd_cnt      <= '0;
            sym_count   <= '0;
            cr_preamble <= 1'b0;
            bit_valid   <= 1'b0;
            bit_data    <= 1'b0;
            search_to   <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            search_to <= 1'b0;

            // Preamble flag spans the whole en window of the hit, dropping on the next en sample.
            if (abort) begin
                cr_preamble <= 1'b0;
            end else if (en) begin
                cr_preamble <= take_hit;
            end

            if (accept_start) begin
                num_lat    <= num_symbols;
                to_lat     <= search_timeout;
                sym_count  <= '0;
                search_cnt <= '0;
            end

            if (!abort) begin
                // A zero timeout means wait forever, so the counter is parked to avoid wrapping.
                if (take_hit) begin
                    settle_cnt <= '0;
                end else if ((state == S_SEARCH) && en && (to_lat != '0)) begin
                    search_cnt <= search_inc;
                end
                search_to <= search_expire;

                if ((state == S_SETTLE) && en) begin
                    settle_cnt <= settle_cnt + ST_ONE;
                    if (settle_end) wd_cnt <= '0;
                end

                if (take_bit) begin
                    bit_valid <= 1'b1;
                    bit_data  <= demod_bit;
                    sym_count <= sym_inc;
                    wd_cnt    <= '0;
                end else if ((state == S_TRACK) && en) begin
                    wd_cnt <= wd_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_timing_ctrl.sv
// Directed bench for rx_timing_ctrl: normal packet, en-toggled packet, search timeout,
// lock loss, abort in SETTLE/TRACK, and asynchronous reset mid-packet.
module tb_rx_timing_ctrl;

    localparam int LEN_W       = 10;
    localparam int SEARCH_TO_W = 12;

    logic                   clk = 1'b0;
    logic                   resetn = 1'b0;
    logic                   en = 1'b0;
    logic                   start = 1'b0;
    logic                   abort = 1'b0;
    logic [LEN_W-1:0]       num_symbols = '0;
    logic [SEARCH_TO_W-1:0] search_timeout = '0;
    logic                   preamble_hit = 1'b0;
    logic                   symbol_clk = 1'b0;
    logic                   demod_bit = 1'b0;
    logic                   cr_en;
    logic                   cr_preamble;
    logic                   bit_valid;
    logic                   bit_data;
    logic [LEN_W-1:0]       sym_count;
    logic                   busy;
    logic                   packet_done;
    logic                   lock_lost;
    logic                   search_to;

    int n_checks = 0;
    int n_pass   = 0;

    // Observation state, cleared at each start.
    int       cur_sample;
    int       nbits;
    int       first_bv;
    int       done_cnt;
    int       done_last;
    int       busy_after_done;
    int       pre_rises;
    int       ll_cnt;
    int       ll_sample;
    int       st_cnt;
    int       st_sample;
    int       gate_bad;
    logic [7:0] got_bits;
    logic     pre_q;
    logic     prev_done;
    logic     toggle_en;

    rx_timing_ctrl dut (
        .clk            (clk),
        .resetn         (resetn),
        .en             (en),
        .start          (start),
        .abort          (abort),
        .num_symbols    (num_symbols),
        .search_timeout (search_timeout),
        .preamble_hit   (preamble_hit),
        .symbol_clk     (symbol_clk),
        .demod_bit      (demod_bit),
        .cr_en          (cr_en),
        .cr_preamble    (cr_preamble),
        .bit_valid      (bit_valid),
        .bit_data       (bit_data),
        .sym_count      (sym_count),
        .busy           (busy),
        .packet_done    (packet_done),
        .lock_lost      (lock_lost),
        .search_to      (search_to)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic clear_mon();
        cur_sample      = -1;
        nbits           = 0;
        first_bv        = -1;
        done_cnt        = 0;
        done_last       = 0;
        busy_after_done = 0;
        pre_rises       = 0;
        ll_cnt          = 0;
        ll_sample       = -1;
        st_cnt          = 0;
        st_sample       = -1;
        gate_bad        = 0;
        got_bits        = 8'h00;
        pre_q           = 1'b0;
        prev_done       = 1'b0;
    endtask

    task automatic observe();
        if (prev_done && busy) busy_after_done++;
        prev_done = packet_done;
        if (bit_valid) begin
            nbits++;
            got_bits = {got_bits[6:0], bit_data};
            if (first_bv < 0) first_bv = cur_sample;
        end
        if (packet_done) begin
            done_cnt++;
            if (bit_valid && nbits == 8) done_last++;
        end
        if (cr_preamble && !pre_q) pre_rises++;
        pre_q = cr_preamble;
        if (lock_lost) begin
            ll_cnt++;
            ll_sample = cur_sample;
        end
        if (search_to) begin
            st_cnt++;
            st_sample = cur_sample;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        observe();
    endtask

    // One en-qualified sample; in toggle mode an en=0 cycle follows carrying junk that must be ignored.
    task automatic sample(input logic hit, input logic sclk, input logic dbit, input logic ab);
        en           = 1'b1;
        preamble_hit = hit;
        symbol_clk   = sclk;
        demod_bit    = dbit;
        abort        = ab;
        tick();
        if (toggle_en) begin
            en           = 1'b0;
            preamble_hit = 1'b1;
            symbol_clk   = 1'b1;
            demod_bit    = ~dbit;
            abort        = 1'b0;
            tick();
            if (cr_en !== 1'b0) gate_bad++;
        end
        en           = 1'b0;
        preamble_hit = 1'b0;
        symbol_clk   = 1'b0;
        abort        = 1'b0;
    endtask

    task automatic do_start(input int num, input int to);
        start          = 1'b1;
        num_symbols    = LEN_W'(num);
        search_timeout = SEARCH_TO_W'(to);
        tick();
        start = 1'b0;
        clear_mon();
    endtask

    // Preamble at sample 20, strobes at samples = 5 mod 16; tracked strobes start at sample 37.
    task automatic run_packet(input logic toggle, input int max_bits, input int nsamp);
        logic [7:0] pat;
        int idx;
        pat = 8'b1011_0010;
        idx = 0;
        toggle_en = 1'b0;
        do_start(8, 0);
        toggle_en = toggle;
        for (int s = 0; s < nsamp; s++) begin
            logic sclk;
            logic dbit;
            cur_sample = s;
            sclk = (s % 16 == 5) && !(s >= 30 && idx >= max_bits);
            dbit = 1'b1;
            if (sclk && s >= 30) begin
                dbit = (idx < 8) ? pat[7-idx] : 1'b0;
                idx++;
            end
            sample(s == 20, sclk, dbit, 1'b0);
        end
        toggle_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        toggle_en = 1'b0;
        clear_mon();
        #12;
        check("reset_outputs",
              int'({cr_en, cr_preamble, bit_valid, bit_data, busy, packet_done,
                    lock_lost, search_to, sym_count}), 0);
        resetn = 1'b1;
        #3;

        // Continuous-en packet.
        run_packet(1'b0, 8, 160);
        check("pkt_bits", nbits, 8);
        check("pkt_pattern", int'(got_bits), 'hB2);
        check("pkt_first_bit_sample", first_bv, 37);
        check("pkt_preamble_pulses", pre_rises, 1);
        check("pkt_done_with_last", done_last, 1);
        check("pkt_done_count", done_cnt, 1);
        check("pkt_busy_after_done", busy_after_done, 0);
        check("pkt_sym_count", int'(sym_count), 8);
        check("pkt_busy_end", int'(busy), 0);

        // Same packet with en alternating 1/0.
        run_packet(1'b1, 8, 160);
        check("tog_bits", nbits, 8);
        check("tog_pattern", int'(got_bits), 'hB2);
        check("tog_first_bit_sample", first_bv, 37);
        check("tog_preamble_pulses", pre_rises, 1);
        check("tog_done_with_last", done_last, 1);
        check("tog_cr_en_gated", gate_bad, 0);
        check("tog_sym_count", int'(sym_count), 8);

        // Search timeout of 50 samples with no preamble.
        do_start(8, 50);
        for (int s = 0; s < 60; s++) begin
            cur_sample = s;
            sample(1'b0, (s % 16 == 5), 1'b1, 1'b0);
        end
        check("to_sample", st_sample, 49);
        check("to_pulses", st_cnt, 1);
        check("to_bits", nbits, 0);
        check("to_busy", int'(busy), 0);

        // Strobes stop after three bits.
        run_packet(1'b0, 3, 120);
        check("ll_bits", nbits, 3);
        check("ll_pattern", int'(got_bits), 5);
        check("ll_sample", ll_sample, 101);
        check("ll_pulses", ll_cnt, 1);
        check("ll_sym_count", int'(sym_count), 3);
        check("ll_no_done", done_cnt, 0);

        // Abort while settling.
        do_start(8, 0);
        for (int s = 0; s < 8; s++) begin
            cur_sample = s;
            sample(s == 5, 1'b0, 1'b0, 1'b0);
        end
        cur_sample = 8;
        sample(1'b0, 1'b1, 1'b1, 1'b1);
        check("abort_settle_busy", int'(busy), 0);
        for (int s = 9; s < 50; s++) begin
            cur_sample = s;
            sample(1'b0, (s % 16 == 5), 1'b1, 1'b0);
        end
        check("abort_settle_bits", nbits, 0);

        // Abort in TRACK coinciding with a strobe.
        do_start(8, 0);
        for (int s = 0; s < 25; s++) begin
            cur_sample = s;
            sample(s == 5, s == 20, 1'b1, 1'b0);
        end
        cur_sample = 25;
        sample(1'b0, 1'b1, 1'b0, 1'b1);
        check("abort_track_no_bit", int'(bit_valid), 0);
        check("abort_track_busy", int'(busy), 0);
        check("abort_track_sym_count", int'(sym_count), 1);
        check("abort_track_no_done", done_cnt, 0);

        run_packet(1'b0, 8, 160);
        check("post_abort_bits", nbits, 8);
        check("post_abort_pattern", int'(got_bits), 'hB2);
        check("post_abort_sym_count", int'(sym_count), 8);

        // Reset mid-TRACK right after a bit.
        do_start(8, 0);
        for (int s = 0; s < 20; s++) begin
            cur_sample = s;
            sample(s == 5, 1'b0, 1'b0, 1'b0);
        end
        cur_sample = 20;
        sample(1'b0, 1'b1, 1'b1, 1'b0);
        check("rst_pre_bit_valid", int'(bit_valid), 1);
        en = 1'b1;
        #1;
        resetn = 1'b0;
        #1;
        check("rst_async_outputs",
              int'({cr_en, cr_preamble, bit_valid, bit_data, busy, packet_done,
                    lock_lost, search_to, sym_count}), 0);
        #3;
        resetn = 1'b1;
        en = 1'b0;
        do_start(0, 0);
        check("zero_len_start_busy", int'(busy), 0);
        for (int i = 0; i < 3; i++) sample(1'b1, 1'b1, 1'b1, 1'b0);
        check("zero_len_idle", int'({busy, cr_en, cr_preamble}), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
